// File: rtl/vga_draw_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : vga_draw_arbiter
//  Purpose  : Grants the single VGA write port to one of five pixel-burst
//             requesters and registers the granted pixel stream with clipping.
//             Define ARB_ROUND_ROBIN_EN for round-robin arbitration; the
//             default build uses fixed priority (highest index wins).
//  Revision : 1.0 - initial release
// ============================================================================
module vga_draw_arbiter #(
    parameter int X_MAX = 320,
    parameter int Y_MAX = 240
) (
    input  logic        CLOCK_50,
    input  logic        resetn,
    input  logic [4:0]  req,
    input  logic [4:0]  last,
    input  logic [44:0] req_x,
    input  logic [44:0] req_y,
    input  logic [14:0] req_colour,
    output logic [4:0]  grant,
    output logic [4:0]  done,
    output logic [8:0]  vga_x,
    output logic [8:0]  vga_y,
    output logic [2:0]  vga_colour,
    output logic        vga_plot,
    output logic        busy
);

    localparam logic [9:0] c_x_lim = 10'(X_MAX);
    localparam logic [9:0] c_y_lim = 10'(Y_MAX);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [4:0] r_grant, w_grant_nxt;
    logic [2:0] r_gidx,  w_gidx_nxt;
    logic [4:0] r_done,  w_done_nxt;
    logic [8:0] r_x,     w_x_nxt;
    logic [8:0] r_y,     w_y_nxt;
    logic [2:0] r_colour, w_colour_nxt;
    logic       r_plot,  w_plot_nxt;

    logic [8:0] w_px_x [5];
    logic [8:0] w_px_y [5];
    logic [2:0] w_px_c [5];

    for (genvar gi = 0; gi < 5; gi++) begin : g_unpack
        assign w_px_x[gi] = req_x[9*gi+8 : 9*gi];
        assign w_px_y[gi] = req_y[9*gi+8 : 9*gi];
        assign w_px_c[gi] = req_colour[3*gi+2 : 3*gi];
    end

    logic [8:0] w_sel_x, w_sel_y;
    logic [2:0] w_sel_c;
    logic       w_accept, w_in_range;

    assign w_sel_x    = w_px_x[r_gidx];
    assign w_sel_y    = w_px_y[r_gidx];
    assign w_sel_c    = w_px_c[r_gidx];
    assign w_accept   = req[r_gidx];
    assign w_in_range = ({1'b0, w_sel_x} < c_x_lim) && ({1'b0, w_sel_y} < c_y_lim);

    logic [2:0] w_win_idx;

`ifdef ARB_ROUND_ROBIN_EN
    logic [2:0] r_ptr, w_ptr_nxt;
    logic [3:0] w_cand;
    logic       w_found;

    // Search upward from the index after the last winner, wrapping at 5.
    always_comb begin
        w_win_idx = 3'd0;
        w_found   = 1'b0;
        w_cand    = 4'd0;
        for (int k = 1; k <= 5; k++) begin
            w_cand = {1'b0, r_ptr} + 4'(k);
            if (w_cand >= 4'd5) begin
                w_cand = w_cand - 4'd5;
            end
            if (!w_found && req[w_cand[2:0]]) begin
                w_found   = 1'b1;
                w_win_idx = w_cand[2:0];
            end
        end
    end
`else
    // Later indices overwrite earlier ones, so the highest requester wins.
    always_comb begin
        w_win_idx = 3'd0;
        for (int k = 0; k < 5; k++) begin
            if (req[k]) begin
                w_win_idx = 3'(k);
            end
        end
    end
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_gidx_nxt   = r_gidx;
        w_done_nxt   = 5'd0;
        w_plot_nxt   = 1'b0;
        w_x_nxt      = r_x;
        w_y_nxt      = r_y;
        w_colour_nxt = r_colour;
`ifdef ARB_ROUND_ROBIN_EN
        w_ptr_nxt    = r_ptr;
`endif
        case (r_state)
            ST_IDLE: begin
                if (|req) begin
                    w_state_nxt = ST_BURST;
                    w_grant_nxt = 5'b00001 << w_win_idx;
                    w_gidx_nxt  = w_win_idx;
`ifdef ARB_ROUND_ROBIN_EN
                    w_ptr_nxt   = w_win_idx;
`endif
                end
            end
            ST_BURST: begin
                if (w_accept) begin
                    // Clipped pixels still consume a beat but leave the port idle.
                    if (w_in_range) begin
                        w_plot_nxt   = 1'b1;
                        w_x_nxt      = w_sel_x;
                        w_y_nxt      = w_sel_y;
                        w_colour_nxt = w_sel_c;
                    end
                    if (last[r_gidx]) begin
                        w_done_nxt  = r_grant;
                        w_grant_nxt = 5'd0;
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_grant_nxt = 5'd0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_grant_nxt = 5'd0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            r_state  <= ST_IDLE;
            r_grant  <= 5'd0;
            r_gidx   <= 3'd0;
            r_done   <= 5'd0;
            r_plot   <= 1'b0;
            r_x      <= 9'd0;
            r_y      <= 9'd0;
            r_colour <= 3'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_gidx   <= w_gidx_nxt;
            r_done   <= w_done_nxt;
            r_plot   <= w_plot_nxt;
            r_x      <= w_x_nxt;
            r_y      <= w_y_nxt;
            r_colour <= w_colour_nxt;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Pointer resets to 4 so the first search after reset starts at index 0.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            r_ptr <= 3'd4;
        end else begin
            r_ptr <= w_ptr_nxt;
        end
    end
`endif

    assign grant      = r_grant;
    assign done       = r_done;
    assign vga_x      = r_x;
    assign vga_y      = r_y;
    assign vga_colour = r_colour;
    assign vga_plot   = r_plot;
    assign busy       = |r_grant;

endmodule
`default_nettype wire

// File: tb/tb_vga_draw_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_draw_arbiter
//  Purpose  : Directed self-checking bench for vga_draw_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vga_draw_arbiter;

    logic        CLOCK_50;
    logic        resetn;
    logic [4:0]  req;
    logic [4:0]  last;
    logic [44:0] req_x;
    logic [44:0] req_y;
    logic [14:0] req_colour;
    logic [4:0]  grant;
    logic [4:0]  done;
    logic [8:0]  vga_x;
    logic [8:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic        busy;

    int total = 0;
    int bad   = 0;

    vga_draw_arbiter #(.X_MAX(320), .Y_MAX(240)) dut (
        .CLOCK_50   (CLOCK_50),
        .resetn     (resetn),
        .req        (req),
        .last       (last),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_colour (req_colour),
        .grant      (grant),
        .done       (done),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .busy       (busy)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_px(input int i, input logic [8:0] x, input logic [8:0] y, input logic [2:0] c);
        req_x[9*i +: 9]      = x;
        req_y[9*i +: 9]      = y;
        req_colour[3*i +: 3] = c;
    endtask

    initial begin
        int xs [4];
        int ys [4];
        logic [4:0] first_g, second_g;
        logic [8:0] first_x, second_x;
        int order [6];

        xs = '{10, 11, 10, 11};
        ys = '{20, 20, 21, 21};
`ifdef ARB_ROUND_ROBIN_EN
        first_g  = 5'b00001; first_x  = 9'd5;
        second_g = 5'b10000; second_x = 9'd7;
        order    = '{0, 1, 2, 3, 4, 0};
`else
        first_g  = 5'b10000; first_x  = 9'd7;
        second_g = 5'b00001; second_x = 9'd5;
        order    = '{4, 4, 4, 4, 4, 4};
`endif

        // Reset state
        resetn = 1'b0; req = '0; last = '0;
        req_x = '0; req_y = '0; req_colour = '0;
        tick(); tick();
        chk("rst_grant", 16'(grant), 16'h0);
        chk("rst_done", 16'(done), 16'h0);
        chk("rst_plot", 16'(vga_plot), 16'h0);
        chk("rst_x", 16'(vga_x), 16'h0);
        chk("rst_y", 16'(vga_y), 16'h0);
        chk("rst_colour", 16'(vga_colour), 16'h0);
        chk("rst_busy", 16'(busy), 16'h0);
        resetn = 1'b1;
        tick();
        chk("idle_grant", 16'(grant), 16'h0);

        // Contention: maze and screen together, both single-pixel bursts
        set_px(0, 9'd5, 9'd6, 3'd1);
        set_px(4, 9'd7, 9'd8, 3'd2);
        req = 5'b10001; last = 5'b10001;
        tick();
        chk("cont_g1", 16'(grant), 16'(first_g));
        chk("cont_busy", 16'(busy), 16'h1);
        tick();
        chk("cont_plot1", 16'(vga_plot), 16'h1);
        chk("cont_x1", 16'(vga_x), 16'(first_x));
        chk("cont_done1", 16'(done), 16'(first_g));
        chk("cont_gclr1", 16'(grant), 16'h0);
        req = second_g;
        tick();
        chk("cont_g2", 16'(grant), 16'(second_g));
        chk("cont_nodone", 16'(done), 16'h0);
        tick();
        chk("cont_x2", 16'(vga_x), 16'(second_x));
        chk("cont_done2", 16'(done), 16'(second_g));
        req = '0; last = '0;
        tick();

        // Single 4-pixel burst from the player-draw requester
        set_px(2, 9'd10, 9'd20, 3'b100);
        req = 5'b00100;
        tick();
        chk("burst_grant", 16'(grant), 16'h0004);
        chk("burst_noplot", 16'(vga_plot), 16'h0);
        for (int p = 0; p < 4; p++) begin
            set_px(2, 9'(xs[p]), 9'(ys[p]), 3'b100);
            last[2] = (p == 3);
            tick();
            chk("burst_plot", 16'(vga_plot), 16'h1);
            chk("burst_x", 16'(vga_x), 16'(xs[p]));
            chk("burst_y", 16'(vga_y), 16'(ys[p]));
            chk("burst_col", 16'(vga_colour), 16'h4);
            if (p < 3) begin
                chk("burst_hold", 16'(grant), 16'h0004);
                chk("burst_nodone", 16'(done), 16'h0);
            end else begin
                chk("burst_done", 16'(done), 16'h0004);
                chk("burst_gclr", 16'(grant), 16'h0);
            end
        end
        req = '0; last = '0;
        tick();
        chk("after_plot", 16'(vga_plot), 16'h0);
        chk("after_xhold", 16'(vga_x), 16'd11);
        chk("after_done", 16'(done), 16'h0);

        // Clipping on the special-box requester
        set_px(3, 9'd320, 9'd5, 3'd1);
        req = 5'b01000;
        tick();
        chk("clip_grant", 16'(grant), 16'h0008);
        tick();
        chk("clip_plot0", 16'(vga_plot), 16'h0);
        chk("clip_hold", 16'(grant), 16'h0008);
        set_px(3, 9'd319, 9'd239, 3'd6);
        last[3] = 1'b1;
        tick();
        chk("clip_plot1", 16'(vga_plot), 16'h1);
        chk("clip_x", 16'(vga_x), 16'd319);
        chk("clip_y", 16'(vga_y), 16'd239);
        chk("clip_col", 16'(vga_colour), 16'h6);
        chk("clip_done", 16'(done), 16'h0008);
        req = '0; last = '0;
        tick();

        // Abort on the erase requester after two pixels; stray last ignored
        set_px(1, 9'd100, 9'd50, 3'd2);
        req = 5'b00010;
        tick();
        chk("abort_grant", 16'(grant), 16'h0002);
        tick();
        chk("abort_x1", 16'(vga_x), 16'd100);
        set_px(1, 9'd101, 9'd50, 3'd2);
        tick();
        chk("abort_x2", 16'(vga_x), 16'd101);
        chk("abort_plot2", 16'(vga_plot), 16'h1);
        req = '0; last[1] = 1'b1;
        tick();
        chk("abort_plot", 16'(vga_plot), 16'h0);
        chk("abort_done", 16'(done), 16'h0);
        chk("abort_gclr", 16'(grant), 16'h0);
        chk("abort_busy", 16'(busy), 16'h0);
        last = '0;
        tick();

        // Reset during the third pixel of a maze burst
        set_px(0, 9'd1, 9'd1, 3'd7);
        req = 5'b00001;
        tick();
        chk("mrst_grant", 16'(grant), 16'h0001);
        tick();
        set_px(0, 9'd2, 9'd1, 3'd7);
        tick();
        chk("mrst_x2", 16'(vga_x), 16'd2);
        set_px(0, 9'd3, 9'd1, 3'd7);
        resetn = 1'b0;
        tick();
        chk("mrst_grant0", 16'(grant), 16'h0);
        chk("mrst_plot0", 16'(vga_plot), 16'h0);
        chk("mrst_done0", 16'(done), 16'h0);
        chk("mrst_x0", 16'(vga_x), 16'h0);
        chk("mrst_col0", 16'(vga_colour), 16'h0);
        resetn = 1'b1;
        tick();
        chk("mrst_regrant", 16'(grant), 16'h0001);
        last[0] = 1'b1;
        tick();
        chk("mrst_done", 16'(done), 16'h0001);
        chk("mrst_x3", 16'(vga_x), 16'd3);
        req = '0; last = '0;
        tick();

        // Fairness: everybody requesting single-pixel bursts, from reset
        for (int i = 0; i < 5; i++) set_px(i, 9'(i), 9'(i), 3'(i));
        resetn = 1'b0;
        req = 5'b11111; last = 5'b11111;
        tick();
        resetn = 1'b1;
        for (int n = 0; n < 6; n++) begin
            tick();
            chk("fair_grant", 16'(grant), 16'(5'b00001 << order[n]));
            tick();
            chk("fair_done", 16'(done), 16'(5'b00001 << order[n]));
            chk("fair_x", 16'(vga_x), 16'(order[n]));
        end
        req = '0; last = '0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
